// File: rtl/lut_engine.sv
// Registered lookup table with per-entry valid bits, hardware init sweep and flush.
// Define LUT_FWD_EN to bypass same-address writes into reads in flight.
module lut_engine #(
  parameter int              Asize    = 8,
  parameter int              Dsize    = 16,
  parameter int              Arange   = 1 << Asize,
  parameter logic [Dsize-1:0] INIT_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  output logic             init_done,
  input  logic             wr_en,
  input  logic [Asize-1:0] wr_addr,
  input  logic [Dsize-1:0] wr_data,
  output logic             wr_ready,
  input  logic             rd_en,
  input  logic [Asize-1:0] rd_addr,
  output logic             rd_ready,
  output logic             rd_vld,
  output logic [Dsize-1:0] rd_data,
  output logic             rd_hit
);

  typedef enum logic {INIT, RUN} state_t;

  state_t           state_q, state_d;
  logic [Asize:0]   init_cnt_q, init_cnt_d;

  logic [Dsize-1:0] mem [Arange];
  logic [Arange-1:0] valid_q;

  logic             wr_acc, rd_acc;
  logic             mem_we, mem_wvalid;
  logic [Asize-1:0] mem_waddr;
  logic [Dsize-1:0] mem_wdata;

  logic [Dsize-1:0] mem_rd_q;
  logic             s1_hit_q, s1_vld_q;
  logic             rd_vld_q, rd_hit_q;
  logic [Dsize-1:0] rd_data_q;
  logic [Dsize-1:0] s2_data;
  logic             s2_hit;

  assign init_done = (state_q == RUN);
  assign wr_ready  = init_done;
  assign rd_ready  = init_done;
  assign wr_acc    = wr_en && init_done;
  assign rd_acc    = rd_en && init_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // The sweep and host writes share the single array write port.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    mem_we     = 1'b0;
    mem_waddr  = wr_addr;
    mem_wdata  = wr_data;
    mem_wvalid = 1'b1;
    case (state_q)
      INIT: begin
        if (!init_cnt_q[Asize]) begin
          mem_we     = rst_n;
          mem_waddr  = init_cnt_q[Asize-1:0];
          mem_wdata  = INIT_VAL;
          mem_wvalid = 1'b0;
          init_cnt_d = init_cnt_q + 1'b1;
        end else begin
          state_d = RUN;
        end
        if (flush) begin
          state_d    = INIT;
          init_cnt_d = '0;
        end
      end
      RUN: begin
        mem_we = wr_acc && rst_n;
        if (flush) begin
          state_d    = INIT;
          init_cnt_d = '0;
        end
      end
      default: begin
        state_d    = INIT;
        init_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr]     <= mem_wdata;
      valid_q[mem_waddr] <= mem_wvalid;
    end
    mem_rd_q <= mem[rd_addr];
    s1_hit_q <= valid_q[rd_addr];
  end

`ifdef LUT_FWD_EN
  logic [Asize-1:0] s1_addr_q;
  logic             s1_fwd_q;
  logic [Dsize-1:0] s1_fwd_data_q;

  always_ff @(posedge clk) begin
    s1_addr_q     <= rd_addr;
    s1_fwd_q      <= wr_acc && (wr_addr == rd_addr);
    s1_fwd_data_q <= wr_data;
  end

  // A write landing while the read sits in stage 1 is younger than one captured with it.
  always_comb begin
    s2_data = mem_rd_q;
    s2_hit  = s1_hit_q;
    if (wr_acc && (wr_addr == s1_addr_q)) begin
      s2_data = wr_data;
      s2_hit  = 1'b1;
    end else if (s1_fwd_q) begin
      s2_data = s1_fwd_data_q;
      s2_hit  = 1'b1;
    end
  end
`else
  always_comb begin
    s2_data = mem_rd_q;
    s2_hit  = s1_hit_q;
  end
`endif

  // Flush leaves the pipeline alone; only reset discards reads in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
      rd_hit_q  <= 1'b0;
    end else begin
      s1_vld_q <= rd_acc;
      rd_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        rd_data_q <= s2_data;
        rd_hit_q  <= s2_hit;
      end
    end
  end

  assign rd_vld  = rd_vld_q;
  assign rd_data = rd_data_q;
  assign rd_hit  = rd_hit_q;

endmodule
